// File: rtl/mem_stage_access_if.sv
// Data-memory bus between the memory-stage controller (master) and the data memory (slave).
interface mem_stage_access_if #(
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/mem_stage_access.sv
// Memory-stage access controller: runs lw/sw over a req/ack bus, stalls upstream, registers MEM/WB.
// Optional ack timeout with error pulse is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_stage_access #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               reg_write_m,
   input  logic               mem_to_reg_m,
   input  logic               mem_write_m,
   input  logic [DATA_W-1:0]  alu_result_m,
   input  logic [DATA_W-1:0]  write_data_m,
   input  logic [REG_W-1:0]   write_reg_m,
   input  logic               syscall_m,
   output logic               stall_m,
   mem_stage_access_if.master bus,
   output logic               reg_write_w,
   output logic [DATA_W-1:0]  result_w,
   output logic [REG_W-1:0]   write_reg_w,
   output logic               syscall_w,
   output logic               err_w
);
   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [DATA_W-1:0] ABORT_VALUE = DATA_W'(32'hDEADBEEF);

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   alu_q, alu_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                load_q, load_d;
   logic                rw_c_q, rw_c_d;
   logic [REG_W-1:0]    wr_c_q, wr_c_d;
   logic                sc_c_q, sc_c_d;
   logic                rw_w_q, rw_w_d;
   logic [DATA_W-1:0]   res_w_q, res_w_d;
   logic [REG_W-1:0]    wr_w_q, wr_w_d;
   logic                sc_w_q, sc_w_d;
   logic                err_w_q, err_w_d;
   logic                stall;
   logic                mem_op;
   logic                timeout_hit;

   assign mem_op = mem_to_reg_m | mem_write_m;

`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0] wait_cnt_q, wait_cnt_d;

   assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));

   // Held at zero while idle, so every new access starts counting from zero.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == IDLE) begin
         wait_cnt_d = '0;
      end else if (!bus.mem_ack) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   wire unused_timeout = (TIMEOUT > 0);

   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      alu_d   = alu_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      rw_c_d  = rw_c_q;
      wr_c_d  = wr_c_q;
      sc_c_d  = sc_c_q;
      rw_w_d  = rw_w_q;
      res_w_d = res_w_q;
      wr_w_d  = wr_w_q;
      sc_w_d  = sc_w_q;
      err_w_d = 1'b0;
      stall   = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op) begin
               stall   = 1'b1;
               alu_d   = alu_result_m;
               wdata_d = write_data_m;
               we_d    = mem_write_m;
               load_d  = mem_to_reg_m;
               rw_c_d  = reg_write_m;
               wr_c_d  = write_reg_m;
               sc_c_d  = syscall_m;
               req_d   = 1'b1;
               state_d = ACCESS;
               rw_w_d  = 1'b0;
               sc_w_d  = 1'b0;
            end else begin
               rw_w_d  = reg_write_m;
               res_w_d = alu_result_m;
               wr_w_d  = write_reg_m;
               sc_w_d  = syscall_m;
            end
         end

         ACCESS: begin
            if (bus.mem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               rw_w_d  = rw_c_q;
               res_w_d = load_q ? bus.mem_rdata : alu_q;
               wr_w_d  = wr_c_q;
               sc_w_d  = sc_c_q;
            end else if (timeout_hit) begin
               // Abandon the access and release the pipeline with a poisoned, non-writing result.
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               rw_w_d  = 1'b0;
               res_w_d = ABORT_VALUE;
               wr_w_d  = wr_c_q;
               sc_w_d  = 1'b0;
               err_w_d = 1'b1;
            end else begin
               stall  = 1'b1;
               rw_w_d = 1'b0;
               sc_w_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         alu_q   <= '0;
         wdata_q <= '0;
         load_q  <= 1'b0;
         rw_c_q  <= 1'b0;
         wr_c_q  <= '0;
         sc_c_q  <= 1'b0;
         rw_w_q  <= 1'b0;
         res_w_q <= '0;
         wr_w_q  <= '0;
         sc_w_q  <= 1'b0;
         err_w_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         rw_c_q  <= rw_c_d;
         wr_c_q  <= wr_c_d;
         sc_c_q  <= sc_c_d;
         rw_w_q  <= rw_w_d;
         res_w_q <= res_w_d;
         wr_w_q  <= wr_w_d;
         sc_w_q  <= sc_w_d;
         err_w_q <= err_w_d;
      end
   end

   // The bus sees a word address; the full byte address is kept for store writeback.
   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = {alu_q[DATA_W-1:2], 2'b00};
   assign bus.mem_wdata = wdata_q;

   assign stall_m     = stall;
   assign reg_write_w = rw_w_q;
   assign result_w    = res_w_q;
   assign write_reg_w = wr_w_q;
   assign syscall_w   = sc_w_q;
   assign err_w       = err_w_q;
endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Memory-stage access controller. It consumes the EX/MEM pipeline register outputs and executes lw/sw on the data-memory bus using a req/ack handshake.
- It stalls the upstream pipeline while an access is outstanding.
- It registers the MEM/WB values: selected result, destination register and control bits.
- It sits between the EX/MEM register and the WB stage.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 5, register-index width.
- TIMEOUT, 64, maximum wait cycles for mem_ack (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- reg_write_m  in  1  writeback enable from EX/MEM.
- mem_to_reg_m  in  1  load instruction.
- mem_write_m  in  1  store instruction.
- alu_result_m  in  DATA_W  effective address / ALU result.
- write_data_m  in  DATA_W  store data.
- write_reg_m  in  REG_W  destination register.
- syscall_m  in  1  syscall marker.
- stall_m  out  1  hold EX/MEM and all earlier stages this cycle.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  DATA_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  bus completion.
- mem_rdata  in  DATA_W  load data, valid while mem_ack=1.
- reg_write_w  out  1  MEM/WB writeback enable.
- result_w  out  DATA_W  writeback value.
- write_reg_w  out  REG_W  MEM/WB destination.
- syscall_w  out  1  MEM/WB syscall marker.
- err_w  out  1  access error (the optional feature only ever drives it to 1).

Behaviour:
- Reset: all outputs 0, FSM = IDLE, wait counter 0. Reset is asynchronous: asserting rst_n mid-access drops mem_req immediately and abandons the access; no writeback occurs.
- Memory op present = mem_to_reg_m | mem_write_m.
- FSM states:
  - IDLE (no outstanding access).
  - ACCESS (mem_req asserted, waiting for ack).
- IDLE, no memory op:
  - stall_m=0.
  - Next edge: reg_write_w<=reg_write_m, result_w<=alu_result_m, write_reg_w<=write_reg_m, syscall_w<=syscall_m.
  - Latency 1 cycle.
- IDLE, memory op:
  - stall_m=1 combinationally.
  - Next edge: capture mem_addr<={alu_result_m[DATA_W-1:2],2'b00}, mem_wdata<=write_data_m, mem_we<=mem_write_m, plus load flag, reg_write, write_reg and syscall.
  - Set mem_req<=1 and go to ACCESS.
  - Insert a bubble into W: reg_write_w<=0, syscall_w<=0.
- ACCESS, mem_ack=0:
  - stall_m=1.
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - W bubble each cycle.
- ACCESS, mem_ack=1:
  - stall_m=0, so upstream advances at this edge.
  - Next edge: mem_req<=0, mem_we<=0, state<=IDLE.
  - reg_write_w, write_reg_w and syscall_w <= captured values.
  - result_w <= mem_rdata for a load, or the captured address bits (original alu_result) for a store.
- Minimum memory-op latency: request issued edge N, ack during cycle N+1, W valid after edge N+2. Each extra ack-wait cycle adds one.
- Back-to-back memory ops: the op arriving after the ack edge is new. From IDLE it is re-issued with no merging; mem_req deasserts for exactly one cycle between accesses.
- mem_ack while IDLE is ignored.
- Misaligned address low 2 bits are dropped; no exception.
- Stores with reg_write_m=1 are passed as given; the controller does not second-guess decode.
- result_w for a store keeps the full alu_result_m, including the low bits.

Optional Feature:
- Macro MEM_ACCESS_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack, the FSM aborts: mem_req<=0, state<=IDLE, stall_m=0 in that cycle.
  - W loads reg_write_w<=0, result_w<=32'hDEADBEEF, write_reg_w<=captured value, err_w<=1.
  - err_w is a one-cycle pulse and otherwise 0.
- When undefined: no counter, err_w tied 0, and the FSM waits indefinitely for mem_ack.

Test Plan:
- ALU op (reg_write_m=1, alu_result_m=32'h0000_0010, write_reg_m=5, no mem op) -> one edge later reg_write_w=1, result_w=32'h10, write_reg_w=5; stall_m never 1.
- Load from alu_result_m=32'h0000_1007, mem_ack 3 cycles after mem_req, mem_rdata=32'hCAFEBABE -> mem_addr=32'h1004; stall_m high 4 cycles; result_w=32'hCAFEBABE, write_reg_w as given; reg_write_w=0 during the bubbles.
- Store alu_result_m=32'h20, write_data_m=32'h55AA55AA, ack in first ACCESS cycle -> mem_we=1, mem_wdata=32'h55AA55AA for exactly 1 cycle; W valid two edges after op arrival.
- Load then store back-to-back -> two separate requests with mem_req low for exactly one cycle between them; each written back in order.
- rst_n pulled low during ACCESS -> mem_req=0 immediately; after release FSM=IDLE, W outputs 0, and a late mem_ack is ignored.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT=8, no ack -> abort after 8 ACCESS cycles: err_w pulses 1, result_w=32'hDEADBEEF, reg_write_w=0, stall_m released.
